// File: rtl/timeset_counter.sv
// BCD set-time counter for the egg timer front panel: up/down buttons step an
// mm:ss-style value with ripple carry/borrow, auto-repeat on held buttons, and saturate or wrap at the ends.
module timeset_counter #(
  parameter int NUM_DIGITS   = 4,
  parameter bit SATURATE     = 1'b1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    main_enable,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    clear,
  input  logic                    tick_in,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    at_zero,
  output logic                    at_max,
  output logic                    step_pulse
);

  localparam int W = 4 * NUM_DIGITS;

  // Even digits are ones (0..9), odd digits are tens of a 60-base pair (0..5).
  function automatic logic [3:0] digit_max(input int i);
    return (i % 2 == 0) ? 4'd9 : 4'd5;
  endfunction

  function automatic logic [W-1:0] all_max_value();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIGITS; i++) v[4*i +: 4] = digit_max(i);
    return v;
  endfunction

  localparam logic [W-1:0] ALL_MAX   = all_max_value();
  localparam logic [7:0]   DELAY_LIM = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0]   RATE_LIM  = 8'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  state_t       state, state_nxt;
  logic         dir_up, dir_up_nxt;
  logic [7:0]   tick_cnt, tick_cnt_nxt;
  logic         btn_up_q, btn_down_q;
  logic         up_act, down_act, latched_act;
  logic         step_req;
  logic [7:0]   tick_limit;

  logic [W-1:0] count_inc, count_dec, count_nxt;
  logic         inc_overflow, dec_underflow;
  logic         carry, borrow;
  logic         stepped;

  // Pressing both buttons at once counts as pressing neither.
  assign up_act      = btn_up & ~btn_down;
  assign down_act    = btn_down & ~btn_up;
  assign latched_act = dir_up ? up_act : down_act;
  assign tick_limit  = (state == HOLD) ? DELAY_LIM : RATE_LIM;

  // Ripple increment; a carry out of the top digit means the value was all-max.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= digit_max(i)) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    inc_overflow = carry;
  end

  // Ripple decrement; a borrow out of the top digit means the value was zero.
  always_comb begin
    count_dec = count;
    borrow    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = digit_max(i);
        end else if (count[4*i +: 4] > digit_max(i)) begin
          count_dec[4*i +: 4] = digit_max(i);
          borrow              = 1'b0;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
    dec_underflow = borrow;
  end

  // Button FSM: one step on the press edge, a second after the hold delay, then one per repeat period.
  always_comb begin
    state_nxt    = state;
    dir_up_nxt   = dir_up;
    tick_cnt_nxt = tick_cnt;
    step_req     = 1'b0;
    case (state)
      IDLE: begin
        if (up_act && !btn_up_q) begin
          step_req     = 1'b1;
          dir_up_nxt   = 1'b1;
          tick_cnt_nxt = '0;
          state_nxt    = HOLD;
        end else if (down_act && !btn_down_q) begin
          step_req     = 1'b1;
          dir_up_nxt   = 1'b0;
          tick_cnt_nxt = '0;
          state_nxt    = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!latched_act) begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
        end else if (tick_in) begin
          if (tick_cnt == tick_limit) begin
            step_req     = 1'b1;
            tick_cnt_nxt = '0;
            state_nxt    = REPEAT;
          end else begin
            tick_cnt_nxt = tick_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        tick_cnt_nxt = '0;
      end
    endcase
    if (clear) begin
      state_nxt    = IDLE;
      tick_cnt_nxt = '0;
      step_req     = 1'b0;
    end
  end

  // Value update: clear wins, then an enabled step unless it would saturate.
  always_comb begin
    count_nxt = count;
    stepped   = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (step_req && main_enable) begin
      if (dir_up_nxt) begin
        if (!(inc_overflow && SATURATE)) begin
          count_nxt = count_inc;
          stepped   = 1'b1;
        end
      end else begin
        if (!(dec_underflow && SATURATE)) begin
          count_nxt = count_dec;
          stepped   = 1'b1;
        end
      end
    end
  end

  // Edge registers reset high so a button still held across reset is not seen as a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dir_up     <= 1'b1;
      tick_cnt   <= '0;
      btn_up_q   <= 1'b1;
      btn_down_q <= 1'b1;
      count      <= '0;
      at_zero    <= 1'b1;
      at_max     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state      <= state_nxt;
      dir_up     <= dir_up_nxt;
      tick_cnt   <= tick_cnt_nxt;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      count      <= count_nxt;
      at_zero    <= (count_nxt == '0);
      at_max     <= (count_nxt == ALL_MAX);
      step_pulse <= stepped;
    end
  end

endmodule

// File: tb/tb_timeset_counter.sv
// Self-checking bench for timeset_counter: a saturating and a wrapping instance
// share stimulus; expected values are queued on drive and compared after settle.
`timescale 1ns/1ps
module tb_timeset_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        main_enable = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        clear = 1'b0;
  logic        tick_in = 1'b0;
  logic [15:0] count_s, count_w;
  logic        at_zero_s, at_max_s, step_pulse_s;
  logic        at_zero_w, at_max_w, step_pulse_w;

  timeset_counter #(.NUM_DIGITS(4), .SATURATE(1'b1), .REPEAT_DELAY(8), .REPEAT_RATE(2)) dut_sat (
    .clk(clk), .reset(reset), .main_enable(main_enable), .btn_up(btn_up), .btn_down(btn_down),
    .clear(clear), .tick_in(tick_in), .count(count_s), .at_zero(at_zero_s), .at_max(at_max_s),
    .step_pulse(step_pulse_s));

  timeset_counter #(.NUM_DIGITS(4), .SATURATE(1'b0), .REPEAT_DELAY(8), .REPEAT_RATE(2)) dut_wrap (
    .clk(clk), .reset(reset), .main_enable(main_enable), .btn_up(btn_up), .btn_down(btn_down),
    .clear(clear), .tick_in(tick_in), .count(count_w), .at_zero(at_zero_w), .at_max(at_max_w),
    .step_pulse(step_pulse_w));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        up, dn, en, clr;
    int          cyc;
    logic [15:0] exp_s, exp_w;
    int          ps, pw;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] cs, cw;
    int          ps, pw;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   total = 0;
  int   bad = 0;
  int   np_s = 0;
  int   np_w = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  // Advance n cycles, ending on a falling edge; step pulses are tallied there.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (step_pulse_s) np_s++;
      if (step_pulse_w) np_w++;
    end
  endtask

  task automatic idle_inputs();
    btn_up = 1'b0; btn_down = 1'b0; clear = 1'b0; main_enable = 1'b1; tick_in = 1'b0;
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.name, "/count_sat"}, 32'(count_s), 32'(e.cs));
    check({e.name, "/count_wrap"}, 32'(count_w), 32'(e.cw));
    check({e.name, "/at_zero_sat"}, 32'(at_zero_s), 32'(e.cs == 16'h0000));
    check({e.name, "/at_max_wrap"}, 32'(at_max_w), 32'(e.cw == 16'h5959));
    check({e.name, "/pulses_sat"}, 32'(np_s), 32'(e.ps));
    check({e.name, "/pulses_wrap"}, 32'(np_w), 32'(e.pw));
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t e;
    np_s = 0; np_w = 0;
    e.name = v.name; e.cs = v.exp_s; e.cw = v.exp_w; e.ps = v.ps; e.pw = v.pw;
    sb.push_back(e);
    btn_up = v.up; btn_down = v.dn; main_enable = v.en; clear = v.clr;
    run(v.cyc);
    idle_inputs();
    run(5);
    sb_compare();
  endtask

  task automatic press_up_n(input int n);
    repeat (n) begin
      btn_up = 1'b1; run(1);
      btn_up = 1'b0; run(1);
    end
  endtask

  task automatic tick_pair();
    tick_in = 1'b1; run(1);
    tick_in = 1'b0; run(1);
  endtask

  task automatic do_clear();
    clear = 1'b1; run(1);
    clear = 1'b0; run(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //           name      up    dn    en    clr   cyc  exp_s     exp_w     ps pw
    vecs[0]  = '{"up1",    1'b1, 1'b0, 1'b1, 1'b0, 1, 16'h0001, 16'h0001, 1, 1};
    vecs[1]  = '{"up2",    1'b1, 1'b0, 1'b1, 1'b0, 1, 16'h0002, 16'h0002, 1, 1};
    vecs[2]  = '{"up3",    1'b1, 1'b0, 1'b1, 1'b0, 1, 16'h0003, 16'h0003, 1, 1};
    vecs[3]  = '{"dn1",    1'b0, 1'b1, 1'b1, 1'b0, 1, 16'h0002, 16'h0002, 1, 1};
    vecs[4]  = '{"dn2",    1'b0, 1'b1, 1'b1, 1'b0, 1, 16'h0001, 16'h0001, 1, 1};
    vecs[5]  = '{"dn3",    1'b0, 1'b1, 1'b1, 1'b0, 1, 16'h0000, 16'h0000, 1, 1};
    vecs[6]  = '{"dn_zero",1'b0, 1'b1, 1'b1, 1'b0, 1, 16'h0000, 16'h5959, 0, 1};
    vecs[7]  = '{"both",   1'b1, 1'b1, 1'b1, 1'b0, 3, 16'h0000, 16'h5959, 0, 0};
    vecs[8]  = '{"en_off", 1'b1, 1'b0, 1'b0, 1'b0, 1, 16'h0000, 16'h5959, 0, 0};
    vecs[9]  = '{"up_wrap",1'b1, 1'b0, 1'b1, 1'b0, 1, 16'h0001, 16'h0000, 1, 1};
    vecs[10] = '{"clr_up", 1'b1, 1'b0, 1'b1, 1'b1, 1, 16'h0000, 16'h0000, 0, 0};
    vecs[11] = '{"dn_wrap",1'b0, 1'b1, 1'b1, 1'b0, 1, 16'h0000, 16'h5959, 0, 1};

    // Asynchronous reset state, before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst/count_sat", 32'(count_s), 32'h0);
    check("rst/at_zero_sat", 32'(at_zero_s), 32'd1);
    check("rst/at_max_sat", 32'(at_max_s), 32'd0);
    check("rst/step_pulse_sat", 32'(step_pulse_s), 32'd0);
    check("rst/count_wrap", 32'(count_w), 32'h0);
    run(2);
    reset = 1'b0;
    run(2);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Step timing: count and step_pulse visible right after the press edge, pulse lasts one cycle.
    do_clear();
    btn_up = 1'b1; run(1);
    check("lat/count_sat", 32'(count_s), 32'h0001);
    check("lat/pulse_sat", 32'(step_pulse_s), 32'd1);
    check("lat/pulse_wrap", 32'(step_pulse_w), 32'd1);
    btn_up = 1'b0; run(1);
    check("lat/pulse_gone", 32'(step_pulse_s), 32'd0);

    // Seconds-tens carry into minutes, then climb to the all-max value.
    press_up_n(58);
    v = '{"to_0059", 1'b0, 1'b0, 1'b1, 1'b0, 1, 16'h0059, 16'h0059, 0, 0};
    apply_vec(v);
    v = '{"carry_0100", 1'b1, 1'b0, 1'b1, 1'b0, 1, 16'h0100, 16'h0100, 1, 1};
    apply_vec(v);
    press_up_n(3539);
    v = '{"to_5959", 1'b0, 1'b0, 1'b1, 1'b0, 1, 16'h5959, 16'h5959, 0, 0};
    apply_vec(v);
    check("max/at_max_sat", 32'(at_max_s), 32'd1);
    v = '{"up_at_max", 1'b1, 1'b0, 1'b1, 1'b0, 1, 16'h5959, 16'h0000, 0, 1};
    apply_vec(v);
    check("max/at_max_sat_held", 32'(at_max_s), 32'd1);
    check("max/at_zero_wrap", 32'(at_zero_w), 32'd1);

    // Auto-repeat: press step, delay step after 8 ticks, then one step per 2 ticks.
    do_clear();
    np_s = 0; np_w = 0;
    sb.push_back('{"hold16", 16'h0006, 16'h0006, 6, 6});
    btn_up = 1'b1; run(1);
    for (int k = 1; k <= 16; k++) begin
      tick_pair();
      if (k == 7) check("hold/before_delay", 32'(count_s), 32'h0001);
      if (k == 8) check("hold/delay_step", 32'(count_s), 32'h0002);
      if (k == 9) check("hold/between_rate", 32'(count_s), 32'h0002);
    end
    btn_up = 1'b0; run(2);
    sb_compare();
    // Released: ticks alone must not step.
    np_s = 0; np_w = 0;
    sb.push_back('{"released_ticks", 16'h0006, 16'h0006, 0, 0});
    for (int k = 0; k < 10; k++) tick_pair();
    sb_compare();

    // Held with main_enable low: FSM runs but value stays frozen.
    np_s = 0; np_w = 0;
    sb.push_back('{"en_off_hold", 16'h0006, 16'h0006, 0, 0});
    main_enable = 1'b0; btn_up = 1'b1; run(1);
    for (int k = 0; k < 20; k++) tick_pair();
    btn_up = 1'b0; run(2);
    main_enable = 1'b1; run(1);
    sb_compare();

    // Reset in REPEAT with the button held, right after a step.
    btn_up = 1'b1; run(1);
    for (int k = 0; k < 9; k++) tick_pair();
    tick_in = 1'b1; run(1);
    tick_in = 1'b0;
    check("mid/count_before", 32'(count_s), 32'h0009);
    check("mid/pulse_before", 32'(step_pulse_s), 32'd1);
    reset = 1'b1;
    #1;
    check("mid/count_sat", 32'(count_s), 32'h0);
    check("mid/count_wrap", 32'(count_w), 32'h0);
    check("mid/at_zero", 32'(at_zero_s), 32'd1);
    check("mid/pulse", 32'(step_pulse_s), 32'd0);
    run(2);
    reset = 1'b0;
    np_s = 0; np_w = 0;
    sb.push_back('{"held_after_rst", 16'h0000, 16'h0000, 0, 0});
    for (int k = 0; k < 10; k++) tick_pair();
    btn_up = 1'b0; run(2);
    sb_compare();
    v = '{"repress", 1'b1, 1'b0, 1'b1, 1'b0, 1, 16'h0001, 16'h0001, 1, 1};
    apply_vec(v);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
